// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response types and the beat
// address helper used by the read slave (and future write slave).
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_t;

   typedef logic [1:0] resp_t;
   localparam resp_t OKAY   = 2'b00;
   localparam resp_t SLVERR = 2'b10;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int MAX_AW = 64;

   function automatic logic [MAX_AW-1:0] next_beat_addr(
      input logic [MAX_AW-1:0] addr,
      input logic [2:0]        size,
      input logic [15:0]       len,
      input burst_t            burst
   );
      logic [MAX_AW-1:0] step;
      logic [MAX_AW-1:0] wlen;
      logic [MAX_AW-1:0] res;
      step = MAX_AW'(1) << size;
      wlen = (MAX_AW'(len) + MAX_AW'(1)) << size;
      res  = addr;
      unique case (burst)
         FIXED: res = addr;
         INCR:  res = (addr & ~(step - 1)) + step;
         WRAP:  res = (addr & ~(wlen - 1))
                    | ((addr + step) & (wlen - 1));
         RSVD:  res = addr;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/axi_rd_slave_if.sv
// axi_rd_slave_if: AXI read address and read data channels
// with master/slave modports.
interface axi_rd_slave_if #(
   parameter int A_WIDTH   = 16,
   parameter int D_WIDTH   = 32,
   parameter int ID_WIDTH  = 9,
   parameter int LEN_WIDTH = 8
);
   logic [ID_WIDTH-1:0]  ARID;
   logic [A_WIDTH-1:0]   ARADDR;
   logic [LEN_WIDTH-1:0] ARLEN;
   logic [2:0]           ARSIZE;
   logic [1:0]           ARBURST;
   logic                 ARVALID;
   logic                 ARREADY;
   logic [ID_WIDTH-1:0]  RID;
   logic [D_WIDTH-1:0]   RDATA;
   logic [1:0]           RRESP;
   logic                 RLAST;
   logic                 RVALID;
   logic                 RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/axi_rd_skid.sv
// axi_rd_skid: 2-entry valid/ready skid buffer; the output
// register holds steady while out_ready is low.
module axi_rd_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         s_valid;
   logic [W-1:0] s_data;

   assign in_ready = !s_valid;

   // move data to the output, parking one word when stalled
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         s_valid   <= 1'b0;
         s_data    <= '0;
      end else if (out_ready || !out_valid) begin
         if (s_valid) begin
            out_valid <= 1'b1;
            out_data  <= s_data;
            s_valid   <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid && in_ready) begin
         s_valid <= 1'b1;
         s_data  <= in_data;
      end
   end
endmodule

// File: rtl/axi_rd_slave.sv
// axi_rd_slave: single-burst AXI read slave over a 1-cycle SRAM.
// Define AXI_RD_RANGE_CHK_EN to flag beats beyond memory depth.
module axi_rd_slave
   import axi_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int D_WIDTH   = 32,
   parameter int ID_WIDTH  = 9,
   parameter int LEN_WIDTH = 8,
   parameter int MEM_AW    = 10
) (
   input  logic               clk,
   input  logic               rstn,
   axi_rd_slave_if.slave      bus,
   output logic               mem_re,
   output logic [MEM_AW-1:0]  mem_addr,
   input  logic [D_WIDTH-1:0] mem_rdata
);
   localparam int LB = $clog2(D_WIDTH / 8);
   localparam int CW = LEN_WIDTH + 1;
   localparam int SW = ID_WIDTH + D_WIDTH + 3;

   state_t               state;
   state_t               state_nx;
   logic                 ar_rdy;
   logic                 ar_hs;
   logic                 ar_err;
   logic                 r_hs;
   logic                 issue;
   logic                 beat_err;
   logic [ID_WIDTH-1:0]  id;
   logic [A_WIDTH-1:0]   addr;
   logic [LEN_WIDTH-1:0] len;
   logic [2:0]           size;
   burst_t               burst;
   logic                 err;
   logic [CW-1:0]        left;
   logic [1:0]           occ;
   logic                 p_valid;
   logic                 p_last;
   logic                 p_err;
   logic [D_WIDTH-1:0]   rdata;
   logic                 s_in_valid;
   logic                 s_in_ready;
   logic [SW-1:0]        s_in;
   logic [SW-1:0]        s_out;

   assign bus.ARREADY = ar_rdy;
   assign ar_hs       = bus.ARVALID && ar_rdy;
   assign r_hs        = bus.RVALID && bus.RREADY;
   assign mem_addr    = MEM_AW'(addr >> LB);

`ifdef AXI_RD_RANGE_CHK_EN
   logic oor;
   assign oor      = ((addr >> LB) >> MEM_AW) != '0;
   assign beat_err = err || oor;
`else
   assign beat_err = err;
`endif

   // classify an incoming request as an error burst
   always_comb begin
      ar_err = 1'b0;
      if (bus.ARBURST == 2'b11) ar_err = 1'b1;
      if (bus.ARSIZE > 3'(LB)) ar_err = 1'b1;
      if (bus.ARBURST == 2'b10 &&
          !(bus.ARLEN == LEN_WIDTH'(1) ||
            bus.ARLEN == LEN_WIDTH'(3) ||
            bus.ARLEN == LEN_WIDTH'(7) ||
            bus.ARLEN == LEN_WIDTH'(15)))
         ar_err = 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // next state: leave IDLE on AR, return on the last R beat
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (ar_hs) state_nx = BURST;
         BURST: if (r_hs && bus.RLAST) state_nx = IDLE;
      endcase
   end

   // beat issue; error bursts never touch the memory
   always_comb begin
      issue  = 1'b0;
      mem_re = 1'b0;
      if (state == BURST && left != '0 && (occ != 2'd2 || r_hs))
         issue = 1'b1;
      mem_re = issue && !err;
   end

   // ARREADY is registered so it only rises after reset release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ar_rdy <= 1'b0;
      else       ar_rdy <= (state_nx == IDLE);
   end

   // burst context and per-beat address stepping
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id    <= '0;
         addr  <= '0;
         len   <= '0;
         size  <= '0;
         burst <= FIXED;
         err   <= 1'b0;
         left  <= '0;
      end else if (ar_hs) begin
         id    <= bus.ARID;
         addr  <= bus.ARADDR;
         len   <= bus.ARLEN;
         size  <= bus.ARSIZE;
         burst <= burst_t'(bus.ARBURST);
         err   <= ar_err;
         left  <= CW'(bus.ARLEN) + CW'(1);
      end else if (issue) begin
         addr  <= A_WIDTH'(next_beat_addr(MAX_AW'(addr), size,
                                          16'(len), burst));
         left  <= left - CW'(1);
      end
   end

   // beats issued but not yet accepted on R
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) occ <= '0;
      else       occ <= occ + {1'b0, issue} - {1'b0, r_hs};
   end

   // tag the beat that returns from memory next cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p_err   <= 1'b0;
      end else begin
         p_valid <= issue;
         p_last  <= (left == CW'(1));
         p_err   <= beat_err;
      end
   end

   assign rdata      = p_err ? '0 : mem_rdata;
   assign s_in       = {id, rdata, p_err ? SLVERR : OKAY, p_last};
   assign s_in_valid = p_valid && s_in_ready;

   axi_rd_skid #(.W(SW)) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in),
      .out_valid (bus.RVALID),
      .out_ready (bus.RREADY),
      .out_data  (s_out)
   );

   assign {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST} = s_out;

endmodule

// File: tb/tb_axi_rd_slave.sv
// tb_axi_rd_slave: directed table-driven bench for axi_rd_slave
// with a 1-cycle synchronous memory model.
module tb_axi_rd_slave;

   logic        clk;
   logic        rstn;
   logic        mem_re;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata;
   int          cyc;
   int          n_chk;
   int          n_err;

   axi_rd_slave_if #(
      .A_WIDTH(16), .D_WIDTH(32), .ID_WIDTH(9), .LEN_WIDTH(8)
   ) bus ();

   axi_rd_slave #(
      .A_WIDTH(16), .D_WIDTH(32), .ID_WIDTH(9),
      .LEN_WIDTH(8), .MEM_AW(10)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus.slave),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic [1:0]  burst;
      logic [15:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [8:0]  id;
      logic        nomre;
      logic [7:0]  errm;
      logic [9:0]  ma [8];
   } vec_t;

   typedef struct {
      logic [9:0] a;
      int         cyc;
   } mrec_t;

   typedef struct {
      logic [31:0] d;
      logic [8:0]  id;
      logic [1:0]  resp;
      logic        last;
      int          cyc;
   } beat_t;

   mrec_t mq[$];
   beat_t rq[$];
   vec_t  tbl[11];

`ifdef AXI_RD_RANGE_CHK_EN
   localparam logic [7:0] RM_TOP = 8'b01;
   localparam logic [7:0] RM_HI  = 8'b11;
`else
   localparam logic [7:0] RM_TOP = 8'b00;
   localparam logic [7:0] RM_HI  = 8'b00;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input logic [9:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   always @(posedge clk) if (mem_re) mem_rdata <= pat(mem_addr);

   always @(negedge clk) begin
      if (mem_re) mq.push_back('{a: mem_addr, cyc: cyc});
      if (bus.RVALID && bus.RREADY)
         rq.push_back('{d: bus.RDATA, id: bus.RID, resp: bus.RRESP,
                        last: bus.RLAST, cyc: cyc});
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [1:0] b, input logic [15:0] a, input logic [7:0] l,
      input logic [2:0] s, input logic [8:0] id, input logic nm,
      input logic [7:0] em, input int m0, input int m1,
      input int m2, input int m3);
      vec_t v;
      v.burst = b; v.addr = a; v.len = l; v.size = s;
      v.id = id; v.nomre = nm; v.errm = em;
      for (int i = 0; i < 8; i++) v.ma[i] = '0;
      v.ma[0] = 10'(m0); v.ma[1] = 10'(m1);
      v.ma[2] = 10'(m2); v.ma[3] = 10'(m3);
      return v;
   endfunction

   task automatic start_ar(input vec_t v, output int arc);
      int t;
      @(posedge clk); #1;
      mq.delete();
      rq.delete();
      bus.ARID    = v.id;
      bus.ARADDR  = v.addr;
      bus.ARLEN   = v.len;
      bus.ARSIZE  = v.size;
      bus.ARBURST = v.burst;
      bus.ARVALID = 1'b1;
      t = 0;
      while (!bus.ARREADY && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("ar_ready", 64'(bus.ARREADY), 64'd1);
      arc = cyc;
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int n);
      int t;
      t = 0;
      while (rq.size() < n && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk({nm, "_done"}, 64'(rq.size() >= n), 64'd1);
      chk({nm, "_arready_after"}, 64'(bus.ARREADY), 64'd1);
      repeat (4) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_vec(input string nm, input vec_t v,
                            input int arc, input bit timing);
      int n;
      bit ok;
      logic [31:0] ed;
      n = int'(v.len) + 1;
      chk({nm, "_nmre"}, 64'(mq.size()), 64'(v.nomre ? 0 : n));
      if (!v.nomre)
         for (int i = 0; i < n && i < mq.size(); i++)
            chk($sformatf("%s_maddr%0d", nm, i),
                64'(mq[i].a), 64'(v.ma[i]));
      chk({nm, "_nbeats"}, 64'(rq.size()), 64'(n));
      for (int i = 0; i < n && i < rq.size(); i++) begin
         ed = v.errm[i] ? 32'd0 : pat(v.ma[i]);
         chk($sformatf("%s_data%0d", nm, i), 64'(rq[i].d), 64'(ed));
         chk($sformatf("%s_resp%0d", nm, i), 64'(rq[i].resp),
             64'(v.errm[i] ? 2'b10 : 2'b00));
         chk($sformatf("%s_last%0d", nm, i), 64'(rq[i].last),
             64'(i == n - 1));
         chk($sformatf("%s_id%0d", nm, i), 64'(rq[i].id), 64'(v.id));
      end
      if (timing) begin
         ok = 1'b1;
         if (!v.nomre)
            for (int i = 0; i < mq.size(); i++)
               if (mq[i].cyc != arc + 1 + i) ok = 1'b0;
         for (int i = 0; i < rq.size(); i++)
            if (rq[i].cyc != arc + 3 + i) ok = 1'b0;
         chk({nm, "_timing"}, 64'(ok), 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t bv;
      int   arc;
      int   t;
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      rstn  = 1'b0;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
      bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b1;

      tbl[0]  = mk(2'b01, 16'h0010, 8'd3, 3'd2, 9'h155, 0, 8'h00,
                   4, 5, 6, 7);
      tbl[1]  = mk(2'b10, 16'h0038, 8'd3, 3'd2, 9'h0A3, 0, 8'h00,
                   14, 15, 12, 13);
      tbl[2]  = mk(2'b00, 16'h0020, 8'd2, 3'd2, 9'h001, 0, 8'h00,
                   8, 8, 8, 0);
      tbl[3]  = mk(2'b01, 16'h0001, 8'd3, 3'd0, 9'h002, 0, 8'h00,
                   0, 0, 0, 1);
      tbl[4]  = mk(2'b10, 16'h000C, 8'd1, 3'd2, 9'h003, 0, 8'h00,
                   3, 2, 0, 0);
      tbl[5]  = mk(2'b01, 16'h0013, 8'd2, 3'd2, 9'h004, 0, 8'h00,
                   4, 5, 6, 0);
      tbl[6]  = mk(2'b01, 16'hFFFC, 8'd1, 3'd2, 9'h005, 0, RM_TOP,
                   1023, 0, 0, 0);
      tbl[7]  = mk(2'b11, 16'h0000, 8'd1, 3'd2, 9'h006, 1, 8'hFF,
                   0, 0, 0, 0);
      tbl[8]  = mk(2'b01, 16'h0000, 8'd1, 3'd3, 9'h007, 1, 8'hFF,
                   0, 0, 0, 0);
      tbl[9]  = mk(2'b10, 16'h0000, 8'd2, 3'd2, 9'h008, 1, 8'hFF,
                   0, 0, 0, 0);
      tbl[10] = mk(2'b01, 16'h1000, 8'd1, 3'd2, 9'h009, 0, RM_HI,
                   0, 1, 0, 0);

      bv = mk(2'b01, 16'h0040, 8'd7, 3'd2, 9'h1AA, 0, 8'h00,
              16, 17, 18, 19);
      for (int i = 4; i < 8; i++) bv.ma[i] = 10'(16 + i);

      repeat (3) @(negedge clk);
      chk("rst_arready", 64'(bus.ARREADY), 64'd0);
      chk("rst_rvalid",  64'(bus.RVALID), 64'd0);
      chk("rst_rdata",   64'(bus.RDATA), 64'd0);
      chk("rst_mem_re",  64'(mem_re), 64'd0);
      rstn = 1'b1;
      #1;
      chk("rel_arready_pre", 64'(bus.ARREADY), 64'd0);
      @(posedge clk); #1;
      chk("rel_arready_post", 64'(bus.ARREADY), 64'd1);

      for (int k = 0; k < 11; k++) begin
         start_ar(tbl[k], arc);
         wait_done($sformatf("v%0d", k), int'(tbl[k].len) + 1);
         check_vec($sformatf("v%0d", k), tbl[k], arc, 1'b1);
      end

      start_ar(bv, arc);
      t = 0;
      while (rq.size() < 2 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("bp_reach2", 64'(rq.size()), 64'd2);
      bus.RREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_rvalid%0d", i), 64'(bus.RVALID), 64'd1);
         chk($sformatf("bp_rdata%0d", i), 64'(bus.RDATA),
             64'(pat(10'd18)));
         chk($sformatf("bp_mem_re%0d", i), 64'(mem_re), 64'd0);
      end
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
      wait_done("bp", 8);
      check_vec("bp", bv, arc, 1'b0);

      start_ar(bv, arc);
      t = 0;
      while (rq.size() < 2 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_out",
          64'({bus.ARREADY, bus.RVALID, bus.RLAST, bus.RID,
               bus.RDATA, bus.RRESP, mem_re, mem_addr}), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("mid_rel_pre", 64'(bus.ARREADY), 64'd0);
      @(posedge clk); #1;
      chk("mid_rel_post", 64'(bus.ARREADY), 64'd1);
      mq.delete();
      rq.delete();
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("mid_no_residual", 64'(rq.size() + mq.size()), 64'd0);

      start_ar(tbl[0], arc);
      wait_done("post_rst", 4);
      check_vec("post_rst", tbl[0], arc, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
